if_id_skid: RTL and testbench

IF_ID_SKID -- requirements
Module: if_id_skid

---
 rtl/if_id_skid_pkg.sv | 26 ++
 rtl/fetch_entry_reg.sv | 36 +++
 rtl/if_id_skid.sv | 148 ++++++++++++++
 tb/tb_if_id_skid.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_pkg.sv
//------------------------------------------------------------------------------
// Module   : if_id_skid_pkg
// Brief    : Shared fetch-stage constants and skid-buffer state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_id_skid_pkg;

  // Default PC word-address width and instruction width for the fetch path
  localparam int c_PC_W    = 10;
  localparam int c_INSTR_W = 32;

  // Instruction presented to decode when no valid entry is held
  localparam logic [31:0] c_NOP = 32'h0000_0000;

  // The encoding doubles as the occupancy count, so occupancy is the state itself
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage : if_id_skid_pkg

`default_nettype wire

// File: rtl/fetch_entry_reg.sv
//------------------------------------------------------------------------------
// Module   : fetch_entry_reg
// Brief    : One {pc_plus1, instr} storage slot with load enable and async clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_entry_reg
  import if_id_skid_pkg::*;
#(
  parameter int PC_W    = c_PC_W,
  parameter int INSTR_W = c_INSTR_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [PC_W-1:0]    pc_plus1_d,
  input  logic [INSTR_W-1:0] instr_d,
  output logic [PC_W-1:0]    pc_plus1_q,
  output logic [INSTR_W-1:0] instr_q
);

  // Capture a new entry on load; reset returns the slot to an all-zero NOP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_plus1_q <= '0;
      instr_q    <= INSTR_W'(c_NOP);
    end else if (load) begin
      pc_plus1_q <= pc_plus1_d;
      instr_q    <= instr_d;
    end
  end

endmodule : fetch_entry_reg

`default_nettype wire

// File: rtl/if_id_skid.sv
//------------------------------------------------------------------------------
// Module   : if_id_skid
// Brief    : Two-entry skid buffer between instruction fetch and decode.
//            Decode-facing outputs come straight from the head register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int PC_W    = c_PC_W,
  parameter int INSTR_W = c_INSTR_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic               flush,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc_plus1,
  output logic [INSTR_W-1:0] id_instr,
  output logic [1:0]         occupancy
);

  skid_state_t        r_state;
  skid_state_t        w_state_next;

  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_new_pc1;

  logic               w_head_load;
  logic [PC_W-1:0]    w_head_pc1_d;
  logic [INSTR_W-1:0] w_head_instr_d;
  logic               w_tail_load;
  logic [PC_W-1:0]    w_tail_pc1_d;
  logic [INSTR_W-1:0] w_tail_instr_d;
  logic [PC_W-1:0]    w_tail_pc1_q;
  logic [INSTR_W-1:0] w_tail_instr_q;

  // Ready depends on state alone so no combinational path runs from decode back to fetch
  assign if_ready  = (r_state != FULL);
  assign id_valid  = (r_state != EMPTY);
  assign occupancy = r_state;

  // Flush discards both the incoming fetch and any decode handshake on the same edge
  assign w_push    = if_valid && if_ready && !flush;
  assign w_pop     = id_valid && id_ready && !flush;
  assign w_new_pc1 = if_pc + PC_W'(1);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and entry-register steering; head is zeroed whenever it becomes empty
  always_comb begin
    w_state_next   = r_state;
    w_head_load    = 1'b0;
    w_head_pc1_d   = w_new_pc1;
    w_head_instr_d = if_instr;
    w_tail_load    = 1'b0;
    w_tail_pc1_d   = w_new_pc1;
    w_tail_instr_d = if_instr;

    if (flush) begin
      w_state_next   = EMPTY;
      w_head_load    = 1'b1;
      w_head_pc1_d   = '0;
      w_head_instr_d = INSTR_W'(c_NOP);
      w_tail_load    = 1'b1;
      w_tail_pc1_d   = '0;
      w_tail_instr_d = INSTR_W'(c_NOP);
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_next = ONE;
            w_head_load  = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            // Head is consumed and replaced by the new fetch in the same cycle
            w_head_load = 1'b1;
          end else if (w_push) begin
            w_state_next = FULL;
            w_tail_load  = 1'b1;
          end else if (w_pop) begin
            w_state_next   = EMPTY;
            w_head_load    = 1'b1;
            w_head_pc1_d   = '0;
            w_head_instr_d = INSTR_W'(c_NOP);
          end
        end
        FULL: begin
          // No push is possible here because if_ready is low
          if (w_pop) begin
            w_state_next   = ONE;
            w_head_load    = 1'b1;
            w_head_pc1_d   = w_tail_pc1_q;
            w_head_instr_d = w_tail_instr_q;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  fetch_entry_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_head (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_head_load),
    .pc_plus1_d (w_head_pc1_d),
    .instr_d    (w_head_instr_d),
    .pc_plus1_q (id_pc_plus1),
    .instr_q    (id_instr)
  );

  fetch_entry_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_tail (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_tail_load),
    .pc_plus1_d (w_tail_pc1_d),
    .instr_d    (w_tail_instr_d),
    .pc_plus1_q (w_tail_pc1_q),
    .instr_q    (w_tail_instr_q)
  );

endmodule : if_id_skid

`default_nettype wire

// File: tb/tb_if_id_skid.sv
//------------------------------------------------------------------------------
// Module   : tb_if_id_skid
// Brief    : Directed self-checking bench for the IF/ID skid buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_id_skid;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic               clock;
  logic               reset_n;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic               if_ready;
  logic               flush;
  logic               id_ready;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc_plus1;
  logic [INSTR_W-1:0] id_instr;
  logic [1:0]         occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_A  = 32'hA000_000A;
  localparam logic [31:0] I_B  = 32'hB000_000B;
  localparam logic [31:0] I_C  = 32'hC000_000C;
  localparam logic [31:0] I_5  = 32'h5555_0005;
  localparam logic [31:0] I_6  = 32'h6666_0006;
  localparam logic [31:0] I_7  = 32'h7777_0007;
  localparam logic [31:0] I_20 = 32'h2020_2020;
  localparam logic [31:0] I_21 = 32'h2121_2121;
  localparam logic [31:0] I_30 = 32'h3030_3030;
  localparam logic [31:0] I_X  = 32'hDEAD_BEEF;
  localparam logic [31:0] I_8  = 32'h0808_0808;

  if_id_skid #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .flush       (flush),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc_plus1 (id_pc_plus1),
    .id_instr    (id_instr),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] pc1,
                          input logic [31:0] ins, input logic [31:0] occ);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, "_pc1"}, {22'd0, id_pc_plus1}, pc1);
    chk({tag, "_instr"}, id_instr, ins);
    chk({tag, "_occ"}, {30'd0, occupancy}, occ);
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = ins;
  endtask

  initial begin
    reset_n  = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    if_valid = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;

    // Reset state
    #3;
    chk_head("reset", 1'b0, 32'd0, 32'd0, 32'd0);
    chk("reset_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    step();
    reset_n = 1'b1;

    // Streaming: one push per cycle with decode always ready
    id_ready = 1'b1;
    push(10'd0, I_A);
    step();
    chk_head("stream0", 1'b1, 32'd1, I_A, 32'd1);
    push(10'd1, I_B);
    step();
    chk_head("stream1", 1'b1, 32'd2, I_B, 32'd1);
    push(10'd2, I_C);
    step();
    chk_head("stream2", 1'b1, 32'd3, I_C, 32'd1);
    if_valid = 1'b0;
    step();
    chk_head("stream_drain", 1'b0, 32'd0, 32'd0, 32'd0);

    // Stall: decode not ready, two pushes fill the buffer, third is refused
    id_ready = 1'b0;
    push(10'd5, I_5);
    step();
    chk_head("stall1", 1'b1, 32'd6, I_5, 32'd1);
    push(10'd6, I_6);
    step();
    chk_head("stall2", 1'b1, 32'd6, I_5, 32'd2);
    chk("stall2_if_ready", {31'd0, if_ready}, 32'd0);
    push(10'd7, I_7);
    step();
    chk_head("stall3_hold", 1'b1, 32'd6, I_5, 32'd2);
    if_valid = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("stall_ready_no_comb", {31'd0, if_ready}, 32'd0);
    step();
    chk_head("stall_pop1", 1'b1, 32'd7, I_6, 32'd1);
    chk("stall_pop1_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    chk_head("stall_pop2", 1'b0, 32'd0, 32'd0, 32'd0);

    // Flush from FULL with a concurrent push and pop request
    id_ready = 1'b0;
    push(10'd20, I_20);
    step();
    push(10'd21, I_21);
    step();
    chk_head("flush_pre", 1'b1, 32'd21, I_20, 32'd2);
    flush    = 1'b1;
    id_ready = 1'b1;
    push(10'd30, I_30);
    step();
    chk_head("flush", 1'b0, 32'd0, 32'd0, 32'd0);
    flush    = 1'b0;
    if_valid = 1'b0;
    step();
    chk_head("flush_after", 1'b0, 32'd0, 32'd0, 32'd0);

    // PC wrap on increment
    push(10'h3FF, I_X);
    step();
    chk_head("wrap", 1'b1, 32'd0, I_X, 32'd1);
    if_valid = 1'b0;
    step();
    chk_head("wrap_drain", 1'b0, 32'd0, 32'd0, 32'd0);

    // Reset mid-operation while FULL, asserted between edges
    id_ready = 1'b0;
    push(10'd40, I_5);
    step();
    push(10'd41, I_6);
    step();
    chk("rst_pre_occ", {30'd0, occupancy}, 32'd2);
    if_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_head("rst_async", 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rst_async_if_ready", {31'd0, if_ready}, 32'd1);
    #2;
    reset_n  = 1'b1;
    id_ready = 1'b1;
    push(10'd8, I_8);
    step();
    chk_head("rst_first_push", 1'b1, 32'd9, I_8, 32'd1);
    if_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_if_id_skid

`default_nettype wire
